// File: rtl/mem_gray_sweeper.sv
// mem_gray_sweeper
//   Sequencer in front of a small byte memory. It walks a range of addresses.
//   For each address it reads the byte, converts it (binary->Gray or Gray->binary)
//   and writes it back in place. Each word takes two cycles (READ then WRITE).
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            begin a sweep (sampled only while idle)
//   i_mode             0 = binary->Gray, 1 = Gray->binary (latched at start)
//   i_start_addr       first address of the sweep (latched at start)
//   i_length           number of words, 0..2**ADDR_W; larger values are clamped
//   o_busy             high while reading/writing
//   o_done             one-cycle pulse when a sweep finishes (also for length 0)
//   o_words_done       words written back in the current/last sweep
//   o_mem_addr/ren/wen/din, i_mem_dout   memory port (memory writes on negedge)
module mem_gray_sweeper #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_words_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << ADDR_W);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              r_state;
  logic                r_mode;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_words;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_busy;
  logic                r_done;
  logic                r_ren;
  logic                r_wen;
  logic [LEN_W-1:0]    w_words_nxt;
  logic [LEN_W-1:0]    w_len_clamped;

  function automatic logic [DATA_W-1:0] bin2gray(input logic [DATA_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR running down from the MSB.
  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] conv(input logic m, input logic [DATA_W-1:0] d);
    return m ? gray2bin(d) : bin2gray(d);
  endfunction

  assign w_words_nxt   = r_words + LEN_W'(1);
  assign w_len_clamped = (i_length > DEPTH) ? DEPTH : i_length;

  // All outputs are registers updated together with the state, so the
  // write data and write enable are stable across the memory's negedge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mode  <= i_mode;
            r_len   <= w_len_clamped;
            r_words <= '0;
            r_addr  <= i_start_addr;
            if (i_length == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
              r_busy  <= 1'b1;
              r_ren   <= 1'b1;
            end
          end
        end
        READ: begin
          // i_mem_dout is only looked at here, while the memory drives it.
          r_din   <= conv(r_mode, i_mem_dout);
          r_ren   <= 1'b0;
          r_wen   <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_wen   <= 1'b0;
          r_words <= w_words_nxt;
          if (w_words_nxt == r_len) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            // Address wraps naturally modulo the memory depth.
            r_addr  <= r_addr + ADDR_W'(1);
            r_ren   <= 1'b1;
            r_state <= READ;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ren   <= 1'b0;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_words_done = r_words;
  assign o_mem_addr   = r_addr;
  assign o_mem_ren    = r_ren;
  assign o_mem_wen    = r_wen;
  assign o_mem_din    = r_din;

endmodule

// File: tb/tb_mem_gray_sweeper.sv
// Testbench for mem_gray_sweeper: directed sweeps against a behavioural
// 64-byte memory (combinational read, negedge write).
module tb_mem_gray_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [5:0] start_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;
  logic [6:0] words_done;
  logic [5:0] mem_addr;
  logic       mem_ren;
  logic       mem_wen;
  logic [7:0] mem_din;
  wire  [7:0] mem_dout;

  logic [7:0] mem [64];
  logic       tb_load = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_gray_sweeper #(.ADDR_W(6), .DATA_W(8), .LEN_W(7)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_mode       (mode),
    .i_start_addr (start_addr),
    .i_length     (length),
    .o_busy       (busy),
    .o_done       (done),
    .o_words_done (words_done),
    .o_mem_addr   (mem_addr),
    .o_mem_ren    (mem_ren),
    .o_mem_wen    (mem_wen),
    .o_mem_din    (mem_din),
    .i_mem_dout   (mem_dout)
  );

  assign mem_dout = mem_ren ? mem[mem_addr] : 8'hzz;

  // Single writer for the memory: either a bench-side preload of mem[i]=i
  // or a DUT write on the falling edge.
  always @(negedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_ident();
    tb_load = 1'b1;
    @(negedge clk);
    #1 tb_load = 1'b0;
  endtask

  // Runs one sweep. cyc is the number of edges from the start edge up to
  // and including the edge that raises done. With pulse set, start is
  // re-asserted with different parameters while busy and in the DONE cycle.
  task automatic run(input logic m, input logic [5:0] a, input logic [6:0] n,
                     input bit pulse, output int cyc, output int wens,
                     output int rens, output int busys);
    start = 1'b1; mode = m; start_addr = a; length = n;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; wens = 0; rens = 0; busys = 0;
    while (!done && cyc < 300) begin
      wens  += int'(mem_wen);
      rens  += int'(mem_ren);
      busys += int'(busy);
      if (pulse && (cyc == 3 || cyc == 4)) begin
        start = 1'b1; mode = ~m; start_addr = a + 6'd30; length = 7'd2;
      end else begin
        start = 1'b0; mode = m; start_addr = a; length = n;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) check("timeout", 32'(done), 32'd1);
    if (pulse) begin
      start = 1'b1; mode = ~m; start_addr = a + 6'd30; length = 7'd2;
    end
    @(posedge clk); #1;
    start = 1'b0; mode = m; start_addr = a; length = n;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'({busy, mem_ren, mem_wen}), 32'd0);
  endtask

  initial begin
    int cyc, wens, rens, busys, bad;
    rst = 1'b1; start = 1'b0; mode = 1'b0; start_addr = '0; length = '0;

    // 1: reset
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    rst = 1'b0;

    // 2: full binary->Gray sweep
    load_ident();
    run(1'b0, 6'd0, 7'd64, 1'b0, cyc, wens, rens, busys);
    check("full_latency", 32'(cyc), 32'd129);
    check("full_wens", 32'(wens), 32'd64);
    check("full_rens", 32'(rens), 32'd64);
    check("full_words", 32'(words_done), 32'd64);
    check("full_mem0", 32'(mem[0]), 32'h00);
    check("full_mem5", 32'(mem[5]), 32'h07);
    check("full_mem63", 32'(mem[63]), 32'h20);
    check("full_mem42", 32'(mem[42]), 32'h3F);

    // 3: Gray->binary restores identity
    run(1'b1, 6'd0, 7'd64, 1'b0, cyc, wens, rens, busys);
    check("restore_latency", 32'(cyc), 32'd129);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'(i)) bad++;
    check("restore_all", 32'(bad), 32'd0);
    check("restore_mem63", 32'(mem[63]), 32'h3F);

    // 4: wrap from 62, length 4
    load_ident();
    run(1'b0, 6'd62, 7'd4, 1'b0, cyc, wens, rens, busys);
    check("wrap_latency", 32'(cyc), 32'd9);
    check("wrap_words", 32'(words_done), 32'd4);
    check("wrap_mem62", 32'(mem[62]), 32'h21);
    check("wrap_mem63", 32'(mem[63]), 32'h20);
    check("wrap_mem0", 32'(mem[0]), 32'h00);
    check("wrap_mem1", 32'(mem[1]), 32'h01);
    check("wrap_mem2", 32'(mem[2]), 32'h02);
    check("wrap_mem61", 32'(mem[61]), 32'h3D);

    // 5: length 0
    run(1'b0, 6'd5, 7'd0, 1'b0, cyc, wens, rens, busys);
    check("len0_latency", 32'(cyc), 32'd1);
    check("len0_busy", 32'(busys), 32'd0);
    check("len0_wen_ren", 32'(wens + rens), 32'd0);
    check("len0_words", 32'(words_done), 32'd0);
    check("len0_mem5", 32'(mem[5]), 32'h05);

    // Oversized length clamps to the full depth
    load_ident();
    run(1'b0, 6'd0, 7'd100, 1'b0, cyc, wens, rens, busys);
    check("clamp_latency", 32'(cyc), 32'd129);
    check("clamp_wens", 32'(wens), 32'd64);
    check("clamp_mem3", 32'(mem[3]), 32'h02);

    // 6: reset lands on the edge that would start word 3's write
    load_ident();
    start = 1'b1; mode = 1'b0; start_addr = 6'd0; length = 7'd10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 7; c++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_ren", 32'(mem_ren), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wen", 32'(mem_wen), 32'd0);
    check("midrst_words", 32'(words_done), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    wens = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      wens += int'(mem_wen);
      bad  += int'(done);
      @(posedge clk); #1;
    end
    check("midrst_no_wen", 32'(wens), 32'd0);
    check("midrst_no_done", 32'(bad), 32'd0);
    check("midrst_mem1", 32'(mem[1]), 32'h01);
    check("midrst_mem2", 32'(mem[2]), 32'h03);
    check("midrst_mem3", 32'(mem[3]), 32'h03);
    check("midrst_mem9", 32'(mem[9]), 32'h09);

    // start pulses while busy and in DONE are ignored
    load_ident();
    run(1'b0, 6'd10, 7'd4, 1'b1, cyc, wens, rens, busys);
    check("ign_latency", 32'(cyc), 32'd9);
    check("ign_wens", 32'(wens), 32'd4);
    check("ign_words", 32'(words_done), 32'd4);
    check("ign_mem10", 32'(mem[10]), 32'h0F);
    check("ign_mem13", 32'(mem[13]), 32'h0B);
    check("ign_mem14", 32'(mem[14]), 32'h0E);
    check("ign_mem40", 32'(mem[40]), 32'h28);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
